// File: rtl/uart_pkg.sv
// UART receiver shared definitions: FSM state encodings, oversampling
// constants and the parity helper used when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  // Even-parity bit that makes the total count of ones (data + bit) even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Show-ahead synchronous FIFO for received bytes. Pointers carry an extra
// wrap bit so full/empty are told apart without a separate counter.
// A push into a full FIFO without a simultaneous pop is dropped and flagged.
module rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             overrun_q;
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_q[AW-1:0]];
  assign overrun = overrun_q;

  // Storage write; cleared on reset so the head reads 0 when empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= wdata;
    end
  end

  // Pointer update and registered overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= '0;
      rd_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      overrun_q <= push && full && !do_pop;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive front-end: 2-flop synchroniser, 16x baud tick, framing FSM
// and a small byte FIFO towards the CPU. Default frame is 8N1; defining
// UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 4800,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] tick_cnt_q;
  logic          tick;

  logic [2:0]           state_q, state_d;
  logic [3:0]           smp_q, smp_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 ferr_q, ferr_d;
  logic                 push;
  logic                 drop_q;
  logic                 fifo_empty, fifo_full;

`ifdef UART_RX_PARITY_EN
  logic drop_d;
  logic perr_q, perr_d;
  assign parity_err = perr_q;
`else
  assign drop_q     = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Two-flop synchroniser; idles high so a reset never looks like a start bit.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= UART_RX;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Free-running oversample divider; tick is high in the last count.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)    tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + 1'b1;
  end
  assign tick = (tick_cnt_q == CW'(DIV - 1));

  // Framing FSM next-state logic; everything advances only on a baud tick.
  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
`ifdef UART_RX_PARITY_EN
    drop_d  = drop_q;
    perr_d  = 1'b0;
`endif
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_d = ST_START;
            smp_d   = 4'd0;
`ifdef UART_RX_PARITY_EN
            drop_d  = 1'b0;
`endif
          end
        end
        ST_START: begin
          if (smp_q == 4'(MID_SAMPLE)) begin
            state_d = rx_s_q ? ST_IDLE : ST_DATA;
            smp_d   = 4'd0;
            bit_d   = 3'd0;
          end else begin
            smp_d = smp_q + 4'd1;
          end
        end
        ST_DATA: begin
          // 4-bit sample counter wraps 15 -> 0 on its own at each bit boundary.
          smp_d = smp_q + 4'd1;
          if (smp_q == 4'(OVERSAMPLE - 1)) begin
            shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (smp_q == 4'(OVERSAMPLE - 1)) begin
            if (even_parity(shreg_q) != rx_s_q) begin
              perr_d = 1'b1;
              drop_d = 1'b1;
            end
            state_d = ST_STOP;
            smp_d   = 4'd0;
          end else begin
            smp_d = smp_q + 4'd1;
          end
        end
`endif
        ST_STOP: begin
          if (smp_q == 4'(OVERSAMPLE - 1)) begin
            smp_d = 4'd0;
            if (rx_s_q) begin
              push    = !drop_q;
              state_d = ST_IDLE;
            end else begin
              // A frame already flagged for parity reports nothing further.
              ferr_d  = !drop_q;
              state_d = ST_BREAK;
            end
          end else begin
            smp_d = smp_q + 4'd1;
          end
        end
        ST_BREAK: begin
          if (rx_s_q) begin
            state_d = ST_IDLE;
            smp_d   = 4'd0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          smp_d   = 4'd0;
        end
      endcase
    end
  end

  // Framing FSM state registers and registered error pulses.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      smp_q   <= 4'd0;
      bit_q   <= 3'd0;
      shreg_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity discard flag and registered parity error pulse.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      drop_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
      perr_q <= perr_d;
    end
  end
`endif

  assign frame_err = ferr_q;

  rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (sysclk),
    .rst_n   (reset),
    .push    (push),
    .wdata   (shreg_q),
    .pop     (rx_ready),
    .rdata   (rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .overrun (overrun)
  );

  assign rx_valid = !fifo_empty;

  // Full status is only needed inside the FIFO; kept visible for debug.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver, run at a reduced clock/baud ratio
// (divider 4, 64 sysclk per bit). Honours UART_RX_PARITY_EN.
module tb_uart_receiver;

  localparam int CLK_FREQ = 6_400_000;
  localparam int BAUD     = 100_000;
  localparam int BIT_CYC  = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_line = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err, parity_err, overrun;

  int n_cmp = 0;
  int n_err = 0;
  int ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_receiver #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (4)
  ) dut (
    .sysclk     (clk),
    .reset      (rst_n),
    .UART_RX    (rx_line),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pop side of the scoreboard: every accepted byte must match the queue head.
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, rx_data}, 32'hFFFF_FFFF);
      else chk("rx_byte", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
    end
  end

  // Pulse counters for the error outputs.
  always @(posedge clk) begin
    if (frame_err)  ferr_cnt++;
    if (parity_err) perr_cnt++;
    if (overrun)    ovr_cnt++;
  end

  task automatic drive_bit(input logic v, input int cyc);
    @(negedge clk);
    rx_line = v;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BIT_CYC);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b, BIT_CYC);
`endif
    drive_bit(stop, BIT_CYC);
  endtask

  task automatic send_ok(input logic [7:0] b, input logic expect_push);
    if (expect_push) exp_q.push_back(b);
    send_frame(b, 1'b1);
    drive_bit(1'b1, BIT_CYC);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_data", {24'd0, rx_data}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_perr", {31'd0, parity_err}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    repeat (2 * BIT_CYC) @(negedge clk);

    // Two good bytes, consumer always ready
    rx_ready = 1'b1;
    send_ok(8'h54, 1'b1);
    send_ok(8'h0C, 1'b1);
    chk("pair_drained", exp_q.size(), 32'd0);
    chk("pair_ferr", ferr_cnt, 32'd0);

    // Short low glitch on an idle line must not frame anything
    drive_bit(1'b0, BIT_CYC / 4);
    drive_bit(1'b1, 3 * BIT_CYC);
    chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
    chk("glitch_ferr", ferr_cnt, 32'd0);

    // Stop bit low, line held low afterwards (break)
    send_frame(8'hA5, 1'b0);
    drive_bit(1'b0, 15 * BIT_CYC);
    chk("brk_ferr", ferr_cnt, 32'd1);
    chk("brk_valid", {31'd0, rx_valid}, 32'd0);
    drive_bit(1'b1, 2 * BIT_CYC);
    send_ok(8'h3C, 1'b1);
    chk("brk_recover", exp_q.size(), 32'd0);
    chk("brk_ferr_once", ferr_cnt, 32'd1);

    // Overrun: consumer stalled, five bytes into a 4-entry FIFO
    rx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_ok(8'(i), 1'b1);
    chk("ovr_none_yet", ovr_cnt, 32'd0);
    send_ok(8'h05, 1'b0);
    chk("ovr_fifth", ovr_cnt, 32'd1);
    chk("ovr_head", {24'd0, rx_data}, 32'h01);
    chk("ovr_valid", {31'd0, rx_valid}, 32'd1);
    @(negedge clk);
    rx_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("ovr_drained", exp_q.size(), 32'd0);
    chk("ovr_empty", {31'd0, rx_valid}, 32'd0);

    // Reset during data bit 3 with a byte waiting in the FIFO
    rx_ready = 1'b0;
    send_ok(8'h77, 1'b0);
    chk("mid_hold_valid", {31'd0, rx_valid}, 32'd1);
    chk("mid_hold_data", {24'd0, rx_data}, 32'h77);
    drive_bit(1'b0, BIT_CYC);
    drive_bit(1'b0, BIT_CYC);
    drive_bit(1'b0, BIT_CYC);
    drive_bit(1'b1, BIT_CYC);
    drive_bit(1'b1, BIT_CYC / 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, rx_data}, 32'd0);
    chk("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
    rx_line = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * BIT_CYC) @(negedge clk);
    rx_ready = 1'b1;
    send_ok(8'h3C, 1'b1);
    chk("mid_recover", exp_q.size(), 32'd0);

`ifdef UART_RX_PARITY_EN
    // 0x54 has three ones: parity bit 0 is wrong, 1 is right
    drive_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) drive_bit(1'(8'h54 >> i), BIT_CYC);
    drive_bit(1'b0, BIT_CYC);
    drive_bit(1'b1, 2 * BIT_CYC);
    chk("par_bad_perr", perr_cnt, 32'd1);
    chk("par_bad_valid", {31'd0, rx_valid}, 32'd0);
    send_ok(8'h54, 1'b1);
    chk("par_good", exp_q.size(), 32'd0);
    chk("par_perr_total", perr_cnt, 32'd1);
`else
    chk("perr_tied", perr_cnt, 32'd0);
`endif

    chk("final_ferr", ferr_cnt, 32'd1);
    chk("final_ovr", ovr_cnt, 32'd1);
    chk("final_queue", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
